// File: rtl/mxalun_seq.sv
// rtl/mxalun_seq.sv - byte-serial ALU with valid/ready handshake and flag outputs
//
// Purpose: accepts opcode/operands on an in_valid & in_ready edge, then works
// through the operands one byte per clock, LSB byte first, chaining the carry
// between bytes. When every byte is done the result and flags are held with
// out_valid until the consumer takes them.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cs_n       chip select, active low; high blocks acceptance only
//   in_valid   opcode/operands valid
//   in_ready   block can accept (IDLE and selected)
//   opcode     operation select (4 bits)
//   a, b       operands (WIDTH bits)
//   cin        carry in, used by ADC/SBB
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   f          result (WIDTH bits)
//   carry      carry out of the top byte / not-borrow for subtract forms
//   zero       arithmetic/logic result is all zeros
//   a_b        captured a equals captured b

module mxalun_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             carry,
    output logic             zero,
    output logic             a_b
);

    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_SBB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_PASA = 4'h8;
    localparam logic [3:0] OP_PASB = 4'h9;
    localparam logic [3:0] OP_INC  = 4'hA;
    localparam logic [3:0] OP_DEC  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_NOR  = 4'hD;
    localparam logic [3:0] OP_XNOR = 4'hE;
    localparam logic [3:0] OP_CMP  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] f_q;
    logic             carry_q;
    logic             zero_q;
    logic             a_b_q;

    logic             accept;
    logic             release_result;
    logic             last_byte;

    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [7:0]       b_op;
    logic             c_first;
    logic             c_in;
    logic             is_arith;
    logic [8:0]       sum;
    logic [7:0]       res_byte;
    logic [7:0]       f_byte;

    assign in_ready       = (state == IDLE) & ~cs_n;
    assign accept         = in_valid & in_ready;
    assign out_valid      = (state == DONE);
    assign release_result = out_valid & out_ready;
    assign last_byte      = (cnt == LAST_BYTE);

    assign f     = f_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign a_b   = a_b_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)         state_next = RUN;
            RUN:  if (last_byte)      state_next = DONE;
            DONE: if (release_result) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Pick the operand bytes addressed by the byte counter
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt == CW'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
    end

    // Byte slice: the adder sees a + b_op + c_in. Subtract forms invert b,
    // INC/DEC replace b with a constant so one adder covers every arithmetic op.
    always_comb begin
        b_op     = b_byte;
        c_first  = 1'b0;
        is_arith = 1'b1;
        case (op_q)
            OP_ADD:  begin b_op = b_byte;  c_first = 1'b0;  end
            OP_ADC:  begin b_op = b_byte;  c_first = cin_q; end
            OP_SUB:  begin b_op = ~b_byte; c_first = 1'b1;  end
            OP_SBB:  begin b_op = ~b_byte; c_first = cin_q; end
            OP_CMP:  begin b_op = ~b_byte; c_first = 1'b1;  end
            OP_INC:  begin b_op = 8'h00;   c_first = 1'b1;  end
            OP_DEC:  begin b_op = 8'hFF;   c_first = 1'b0;  end
            default: begin b_op = b_byte;  is_arith = 1'b0; end
        endcase

        // Only the first byte uses the opcode carry-in; later bytes take the chain
        c_in = (cnt == '0) ? c_first : carry_q;
        sum  = {1'b0, a_byte} + {1'b0, b_op} + {8'h00, c_in};

        res_byte = sum[7:0];
        case (op_q)
            OP_AND:  res_byte = a_byte & b_byte;
            OP_OR:   res_byte = a_byte | b_byte;
            OP_XOR:  res_byte = a_byte ^ b_byte;
            OP_NOT:  res_byte = ~a_byte;
            OP_PASA: res_byte = a_byte;
            OP_PASB: res_byte = b_byte;
            OP_NAND: res_byte = ~(a_byte & b_byte);
            OP_NOR:  res_byte = ~(a_byte | b_byte);
            OP_XNOR: res_byte = ~(a_byte ^ b_byte);
            default: res_byte = sum[7:0];
        endcase

        // CMP reports a-b through the flags but leaves f equal to a
        f_byte = (op_q == OP_CMP) ? a_byte : res_byte;
    end

    // Capture and byte-serial datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            cnt     <= '0;
            f_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            a_b_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= opcode;
            a_q     <= a;
            b_q     <= b;
            cin_q   <= cin;
            cnt     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            a_b_q   <= (a == b);
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            for (int i = 0; i < NBYTES; i++) begin
                if (cnt == CW'(i)) begin
                    f_q[8*i +: 8] <= f_byte;
                end
            end
            // After the last byte this holds the carry out of the top byte
            carry_q <= is_arith ? sum[8] : 1'b0;
            // Zero accumulates across bytes; the first byte starts it fresh
            zero_q  <= ((cnt == '0) ? 1'b1 : zero_q) & (res_byte == 8'h00);
        end
    end

endmodule

// File: tb/tb_mxalun_seq.sv
// tb/tb_mxalun_seq.sv - self-checking bench for mxalun_seq with a reference model

module tb_mxalun_seq;

    localparam int W      = 16;
    localparam int NBYTES = W / 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cs_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         carry;
    logic         zero;
    logic         a_b;

    int checks = 0;
    int errors = 0;

    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_f;
    logic         exp_c;
    logic         exp_z;
    logic         exp_ab;

    mxalun_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cs_n      (cs_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .carry     (carry),
        .zero      (zero),
        .a_b       (a_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: whole-word integer arithmetic, no byte slicing or carry chain
    task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, output logic [W-1:0] rf, output logic rc,
                         output logic rz, output logic rab);
        longint ax;
        longint by;
        longint t;
        longint full;
        logic [W-1:0] r;
        ax   = longint'(x);
        by   = longint'(y);
        full = longint'(1) << W;
        t    = 0;
        rc   = 1'b0;
        r    = '0;
        case (op)
            4'h0: begin t = ax + by;              rc = (t >= full); r = t[W-1:0]; end
            4'h1: begin t = ax + by + ci;         rc = (t >= full); r = t[W-1:0]; end
            4'h2: begin t = ax - by;              rc = (t >= 0);    r = t[W-1:0]; end
            4'h3: begin t = ax - by - (ci ? 0 : 1); rc = (t >= 0);  r = t[W-1:0]; end
            4'h4: r = x & y;
            4'h5: r = x | y;
            4'h6: r = x ^ y;
            4'h7: r = ~x;
            4'h8: r = x;
            4'h9: r = y;
            4'hA: begin t = ax + 1;               rc = (t >= full); r = t[W-1:0]; end
            4'hB: begin t = ax - 1;               rc = (t >= 0);    r = t[W-1:0]; end
            4'hC: r = ~(x & y);
            4'hD: r = ~(x | y);
            4'hE: r = ~(x ^ y);
            default: begin t = ax - by;           rc = (t >= 0);    r = t[W-1:0]; end
        endcase
        rz  = (r == '0);
        rab = (x == y);
        rf  = (op == 4'hF) ? x : r;
    endtask

    // Every cycle with out_valid high is compared against the model's result
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!exp_valid) begin
                check("unexpected_out_valid", 32'(out_valid), 32'(0));
            end else begin
                check("f", 32'(f), 32'(exp_f));
                check("carry", 32'(carry), 32'(exp_c));
                check("zero", 32'(zero), 32'(exp_z));
                check("a_b", 32'(a_b), 32'(exp_ab));
            end
        end
    end

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input int hold);
        int n;
        @(negedge clk);
        cs_n     = 1'b0;
        opcode   = op;
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        model(op, x, y, ci, exp_f, exp_c, exp_z, exp_ab);
        exp_valid = 1'b1;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        // Inputs are scrambled after accept; they must not affect the result
        in_valid = 1'b0;
        opcode   = 4'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        cs_n     = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 12);
        check("latency", 32'(n), 32'(NBYTES + 1));
        repeat (hold) begin
            check("in_ready_done", 32'(in_ready), 32'(0));
            @(negedge clk);
            check("out_valid_held", 32'(out_valid), 32'(1));
        end
        out_ready = 1'b1;
        cs_n      = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_released", 32'(out_valid), 32'(0));
        check("in_ready_after", 32'(in_ready), 32'(1));
        exp_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] mf;
        logic         mc;
        logic         mz;
        logic         mab;
        logic [W-1:0] x;
        logic [W-1:0] y;

        rst       = 1'b1;
        cs_n      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_f", 32'(f), 32'(0));
        check("rst_carry", 32'(carry), 32'(0));
        check("rst_zero", 32'(zero), 32'(0));
        check("rst_a_b", 32'(a_b), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(1));

        // Hand-computed results that pin the model
        model(4'h0, 16'h00FF, 16'h0001, 1'b0, mf, mc, mz, mab);
        check("pin_add", 32'({mf, mc, mz, mab}), 32'({16'h0100, 1'b0, 1'b0, 1'b0}));
        model(4'h0, 16'hFFFF, 16'h0001, 1'b0, mf, mc, mz, mab);
        check("pin_add_wrap", 32'({mf, mc, mz}), 32'({16'h0000, 1'b1, 1'b1}));
        model(4'h2, 16'h0001, 16'h0002, 1'b0, mf, mc, mz, mab);
        check("pin_sub", 32'({mf, mc}), 32'({16'hFFFF, 1'b0}));
        model(4'hF, 16'h1234, 16'h1234, 1'b0, mf, mc, mz, mab);
        check("pin_cmp", 32'({mf, mc, mz, mab}), 32'({16'h1234, 1'b1, 1'b1, 1'b1}));
        model(4'hB, 16'h0000, 16'h5555, 1'b1, mf, mc, mz, mab);
        check("pin_dec", 32'({mf, mc}), 32'({16'hFFFF, 1'b0}));

        do_op(4'h0, 16'h00FF, 16'h0001, 1'b0, 0);
        do_op(4'h0, 16'hFFFF, 16'h0001, 1'b0, 1);
        do_op(4'h2, 16'h0001, 16'h0002, 1'b0, 0);
        do_op(4'hF, 16'h1234, 16'h1234, 1'b0, 2);
        do_op(4'h1, 16'h80FF, 16'h7F00, 1'b1, 5);
        do_op(4'h3, 16'h0100, 16'h0001, 1'b0, 0);

        // Reset after the first byte edge aborts the operation
        @(negedge clk);
        exp_valid = 1'b0;
        cs_n      = 1'b0;
        opcode    = 4'h0;
        a         = 16'h1111;
        b         = 16'h2222;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_f", 32'(f), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(1));
        repeat (4) @(negedge clk);

        // Deselected: in_valid high must not start an operation
        cs_n     = 1'b1;
        in_valid = 1'b1;
        a        = 16'hABCD;
        b        = 16'h1234;
        repeat (4) begin
            #1;
            check("cs_in_ready", 32'(in_ready), 32'(0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        cs_n     = 1'b0;
        repeat (4) @(negedge clk);
        check("cs_idle_in_ready", 32'(in_ready), 32'(1));
        check("cs_no_result", 32'(out_valid), 32'(0));

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       x = 16'h0000;
                1:       x = 16'hFFFF;
                default: x = W'($urandom);
            endcase
            y = ($urandom_range(0, 4) == 0) ? x : W'($urandom);
            do_op(4'($urandom_range(0, 15)), x, y, 1'($urandom), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
